// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: access-size codes, dump FSM states, width defaults.
package pipeline_pkg;

  localparam int unsigned NB_DATA_DEFAULT = 32;
  localparam int unsigned NB_ADDR_DEFAULT = 7;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'b00,
    DUMP_SEND = 2'b01,
    DUMP_DONE = 2'b10
  } dump_state_e;

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: async read, sync byte-enabled write, second async
// read port used by the debug dump engine. Contents are never reset.
module data_memory #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 7
) (
  input  logic               clk_i,
  input  logic [3:0]         be_i,
  input  logic [NB_ADDR-1:0] waddr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  input  logic [NB_ADDR-1:0] raddr_i,
  output logic [NB_DATA-1:0] rdata_o,
  input  logic [NB_ADDR-1:0] dump_addr_i,
  output logic [NB_DATA-1:0] dump_data_o
);

  localparam int unsigned DEPTH = 2**NB_ADDR;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  // Byte-lane writes at the rising edge.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o     = mem_q[raddr_i];
  assign dump_data_o = mem_q[dump_addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte/half/word loads and stores with extension and
// misalignment detection, plus a handshaked full-memory dump engine.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned NB_DATA      = NB_DATA_DEFAULT,
  parameter int unsigned NB_ADDR      = NB_ADDR_DEFAULT,
  parameter int unsigned NB_BYTE_ADDR = NB_ADDR + 2
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic [1:0]         i_MEM_size,
  input  logic               i_MEM_unsigned,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_write_data,
  output logic [NB_DATA-1:0] o_MEM_mem_data,
  output logic               o_MEM_misaligned,
  input  logic               i_dbg_halted,
  input  logic               i_dbg_dump_start,
  input  logic               i_dbg_ready,
  output logic               o_dbg_valid,
  output logic [NB_ADDR-1:0] o_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_dbg_done
);

  localparam int unsigned        DEPTH    = 2**NB_ADDR;
  localparam logic [NB_ADDR-1:0] CNT_LAST = NB_ADDR'(DEPTH - 1);
  localparam logic [NB_ADDR-1:0] CNT_ONE  = NB_ADDR'(1);

  logic [NB_BYTE_ADDR-1:0] byte_addr;
  logic [NB_ADDR-1:0]      word_idx;
  logic [1:0]              lane;
  logic                    misaligned;
  logic [NB_DATA-1:0]      rd_word;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [NB_DATA-1:0]      load_d;
  logic [3:0]              be_raw;
  logic [3:0]              be;
  logic [NB_DATA-1:0]      st_data;
  logic [NB_ADDR-1:0]      dump_raddr;
  logic [NB_DATA-1:0]      dump_rdata;

  dump_state_e        state_q;
  logic [NB_ADDR-1:0] cnt_q;
  logic               valid_q;
  logic               done_q;
  logic [NB_DATA-1:0] data_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^i_MEM_alu_result[NB_DATA-1:NB_BYTE_ADDR];

  assign byte_addr = i_MEM_alu_result[NB_BYTE_ADDR-1:0];
  assign word_idx  = byte_addr[NB_BYTE_ADDR-1:2];
  assign lane      = byte_addr[1:0];

  // Alignment rule per access size; the reserved code behaves as a word.
  always_comb begin
    misaligned = 1'b0;
    case (i_MEM_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lane[0];
      default:   misaligned = |lane;
    endcase
  end

  assign o_MEM_misaligned = (i_MEM_mem_read | i_MEM_mem_write) & misaligned;

  // Lane selection and sign/zero extension of the loaded word.
  always_comb begin
    ld_byte = rd_word[8*lane +: 8];
    ld_half = byte_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_d  = '0;
    case (i_MEM_size)
      SIZE_BYTE: load_d = i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, ld_byte}
                                         : {{(NB_DATA-8){ld_byte[7]}}, ld_byte};
      SIZE_HALF: load_d = i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, ld_half}
                                         : {{(NB_DATA-16){ld_half[15]}}, ld_half};
      default:   load_d = rd_word;
    endcase
    if (!i_MEM_mem_read || misaligned) load_d = '0;
  end

  assign o_MEM_mem_data = load_d;

  // Store byte enables; data is replicated so every lane sees the low bytes.
  always_comb begin
    be_raw  = 4'b1111;
    st_data = i_MEM_write_data;
    case (i_MEM_size)
      SIZE_BYTE: begin
        be_raw  = 4'b0001 << lane;
        st_data = {4{i_MEM_write_data[7:0]}};
      end
      SIZE_HALF: begin
        be_raw  = byte_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_MEM_write_data[15:0]}};
      end
      default: begin
        be_raw  = 4'b1111;
        st_data = i_MEM_write_data;
      end
    endcase
    be = (i_MEM_mem_write && !misaligned && !i_dbg_halted) ? be_raw : 4'b0000;
  end

  // In SEND the port pre-fetches the next word so an accept can register it.
  assign dump_raddr = (state_q == DUMP_SEND) ? cnt_q + CNT_ONE : '0;

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .clk_i       (i_clock),
    .be_i        (be),
    .waddr_i     (word_idx),
    .wdata_i     (st_data),
    .raddr_i     (word_idx),
    .rdata_o     (rd_word),
    .dump_addr_i (dump_raddr),
    .dump_data_o (dump_rdata)
  );

  // Dump FSM with registered valid/addr/data/done; halt loss aborts silently.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= DUMP_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DUMP_IDLE: begin
          if (i_dbg_dump_start && i_dbg_halted) begin
            cnt_q   <= '0;
            data_q  <= dump_rdata;
            valid_q <= 1'b1;
            state_q <= DUMP_SEND;
          end
        end
        DUMP_SEND: begin
          if (!i_dbg_halted) begin
            valid_q <= 1'b0;
            state_q <= DUMP_IDLE;
          end else if (i_dbg_ready) begin
            if (cnt_q == CNT_LAST) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DUMP_DONE;
            end else begin
              cnt_q  <= cnt_q + CNT_ONE;
              data_q <= dump_rdata;
            end
          end
        end
        DUMP_DONE: state_q <= DUMP_IDLE;
        default:   state_q <= DUMP_IDLE;
      endcase
    end
  end

  assign o_dbg_valid = valid_q;
  assign o_dbg_addr  = cnt_q;
  assign o_dbg_data  = data_q;
  assign o_dbg_done  = done_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        rd, wr, uns;
  logic [1:0]  size;
  logic [31:0] alu, wdata;
  logic [31:0] mem_data;
  logic        mis;
  logic        halted, start, ready;
  logic        dvalid, ddone;
  logic [6:0]  daddr;
  logic [31:0] ddata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_stage #(
    .NB_DATA (32),
    .NB_ADDR (7)
  ) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_MEM_mem_read   (rd),
    .i_MEM_mem_write  (wr),
    .i_MEM_size       (size),
    .i_MEM_unsigned   (uns),
    .i_MEM_alu_result (alu),
    .i_MEM_write_data (wdata),
    .o_MEM_mem_data   (mem_data),
    .o_MEM_misaligned (mis),
    .i_dbg_halted     (halted),
    .i_dbg_dump_start (start),
    .i_dbg_ready      (ready),
    .o_dbg_valid      (dvalid),
    .o_dbg_addr       (daddr),
    .o_dbg_data       (ddata),
    .o_dbg_done       (ddone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h exp=%h", tag, got, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       output logic mis_seen);
    @(negedge clk);
    wr = 1'b1; alu = a; wdata = d; size = sz;
    #1 mis_seen = mis;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] exp_d, input logic exp_m);
    @(negedge clk);
    rd = 1'b1; alu = a; size = sz; uns = u;
    #1;
    check(tag, mem_data, exp_d);
    check({tag, "_mis"}, {31'b0, mis}, {31'b0, exp_m});
    rd = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  logic        m;
  int unsigned exp_idx;
  int unsigned done_cnt;
  logic        seen;
  logic        found;

  initial begin
    rst_n = 1'b1; rd = 0; wr = 0; uns = 0; size = 2'b11; alu = '0; wdata = '0;
    halted = 0; start = 0; ready = 0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid", {31'b0, dvalid}, 32'd0);
    check("rst_done", {31'b0, ddone}, 32'd0);
    check("rst_addr", {25'b0, daddr}, 32'd0);
    check("rst_data", ddata, 32'd0);
    check("rst_noread", mem_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Word store/load and extension.
    store(32'h10, 32'hDEADBEEF, 2'b11, m);
    check("st_word_mis", {31'b0, m}, 32'd0);
    load_chk("ld_word",     32'h10, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);
    load_chk("ld_byte_s",   32'h10, 2'b00, 1'b0, 32'hFFFFFFEF, 1'b0);
    load_chk("ld_byte_u",   32'h10, 2'b00, 1'b1, 32'h000000EF, 1'b0);
    load_chk("ld_byte3_s",  32'h13, 2'b00, 1'b0, 32'hFFFFFFDE, 1'b0);
    load_chk("ld_half_s",   32'h12, 2'b01, 1'b0, 32'hFFFFDEAD, 1'b0);
    load_chk("ld_half_u",   32'h10, 2'b01, 1'b1, 32'h0000BEEF, 1'b0);
    load_chk("ld_rsvd",     32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    load_chk("ld_word_mis", 32'h12, 2'b11, 1'b0, 32'h00000000, 1'b1);
    load_chk("ld_half_mis", 32'h11, 2'b01, 1'b0, 32'h00000000, 1'b1);
    @(negedge clk); alu = 32'h10; size = 2'b11; #1;
    check("ld_disabled", mem_data, 32'd0);

    // Partial stores.
    store(32'h11, 32'hAAAAAA55, 2'b00, m);
    load_chk("st_byte", 32'h10, 2'b11, 1'b0, 32'hDEAD55EF, 1'b0);
    store(32'h12, 32'hFFFF1234, 2'b01, m);
    load_chk("st_half", 32'h10, 2'b11, 1'b0, 32'h123455EF, 1'b0);

    // Suppressed stores.
    store(32'h12, 32'h0BADF00D, 2'b11, m);
    check("st_mis_flag", {31'b0, m}, 32'd1);
    load_chk("st_mis_nochg", 32'h10, 2'b11, 1'b0, 32'h123455EF, 1'b0);
    halted = 1'b1;
    store(32'h10, 32'hFFFFFFFF, 2'b11, m);
    halted = 1'b0;
    load_chk("st_halt_nochg", 32'h10, 2'b11, 1'b0, 32'h123455EF, 1'b0);

    // Read during write returns old contents, then the new word.
    @(negedge clk);
    rd = 1; wr = 1; alu = 32'h10; size = 2'b11; wdata = 32'hCAFEF00D;
    #1 check("rdw_old", mem_data, 32'h123455EF);
    @(posedge clk);
    #1 check("rdw_new", mem_data, 32'hCAFEF00D);
    rd = 0; wr = 0;

    // Preload mem[k] = k*3.
    for (int k = 0; k < 128; k++) store(32'(4*k), 32'(3*k), 2'b11, m);

    // Start without halt is ignored.
    pulse_start();
    check("start_nohalt", {31'b0, dvalid}, 32'd0);

    // Full dump with ready toggling every cycle.
    halted = 1'b1; ready = 1'b0;
    pulse_start();
    exp_idx = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (ddone) begin
        done_cnt++;
        check("done_after_last", exp_idx, 32'd128);
      end
      if (dvalid) begin
        check("dump_addr", {25'b0, daddr}, exp_idx);
        check("dump_data", ddata, exp_idx * 3);
      end
      if (done_cnt != 0) break;
      ready = cyc[0];
      if (dvalid && ready) exp_idx++;
      @(negedge clk);
    end
    ready = 1'b0;
    check("dump_words", exp_idx, 32'd128);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ddone) done_cnt++;
      if (dvalid) seen = 1'b1;
    end
    check("dump_done_once", done_cnt, 32'd1);
    check("dump_idle_valid", {31'b0, seen}, 32'd0);

    // Abort by dropping halt after word 5.
    ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dvalid && daddr == 7'd6) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach_w6", {31'b0, found}, 32'd1);
    halted = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("abort_valid", {31'b0, dvalid}, 32'd0);
    seen = ddone;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | ddone;
    end
    check("abort_nodone", {31'b0, seen}, 32'd0);

    // FSM back in IDLE: a fresh start begins at word 0.
    halted = 1'b1;
    pulse_start();
    check("restart_valid", {31'b0, dvalid}, 32'd1);
    check("restart_addr", {25'b0, daddr}, 32'd0);

    // Reset mid-dump clears outputs immediately.
    ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dvalid && daddr == 7'd9) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("rstmid_pre_data", ddata, 32'd27);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", {31'b0, dvalid}, 32'd0);
    check("rstmid_addr", {25'b0, daddr}, 32'd0);
    check("rstmid_data", ddata, 32'd0);
    check("rstmid_done", {31'b0, ddone}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; halted = 1'b0; ready = 1'b0;
    load_chk("mem_kept5", 32'h14, 2'b11, 1'b0, 32'd15, 1'b0);
    load_chk("mem_kept127", 32'h1FC, 2'b11, 1'b0, 32'd381, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
